// File: rtl/slot_pkg.sv
// Shared definitions for the slot-machine reel generator and the game FSM.
//   - reel_state_e : reel sequencer states
//   - SYM_W_DEF / NUM_SYMS_DEF : default symbol width and symbols per reel
//   - LFSR_RESET / LFSR_TAPS : free-running start-position generator constants
//   - sym_t : symbol type carried on c1..c3 toward the game FSM
package slot_pkg;

   localparam int unsigned SYM_W_DEF    = 3;
   localparam int unsigned NUM_SYMS_DEF = 6;

   localparam int unsigned LFSR_W     = 16;
   localparam logic [15:0] LFSR_RESET = 16'hACE1;
   // Right-shifting form of x^16+x^14+x^13+x^11: feedback from bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAPS  = 16'h002D;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FAST = 2'd1,
      SLOW = 2'd2,
      DONE = 2'd3
   } reel_state_e;

   typedef logic [SYM_W_DEF-1:0] sym_t;

endpackage

// File: rtl/slot_lfsr.sv
// 16-bit Fibonacci LFSR with parallel load, plus the start-position snapshot.
// Ports:
//   clk, reset : clock, synchronous active-high reset (reset beats load)
//   load_i     : load seed_i instead of shifting this cycle
//   seed_i     : load value (must be nonzero)
//   snap_o     : low OUT_W bits of seed_i when loading, else of the current state
module slot_lfsr
   import slot_pkg::*;
#(
   parameter int unsigned OUT_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic [LFSR_W-1:0] seed_i,
   output logic [OUT_W-1:0]  snap_o
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;
   logic              fb_c;

   // Shift right, feedback enters at the MSB.
   always_comb begin
      fb_c   = ^(lfsr_q & LFSR_TAPS);
      lfsr_d = load_i ? seed_i : {fb_c, lfsr_q[LFSR_W-1:1]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= LFSR_RESET;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   // A spin coinciding with a seed load snapshots the seed itself.
   assign snap_o = load_i ? seed_i[OUT_W-1:0] : lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/slot_reels.sv
// Three-reel spin generator feeding the slot-machine game FSM.
// A spin snapshots start positions from a free-running LFSR, steps all reels
// through a fast phase and a slow phase, then stops the reels one at a time.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   spin         : lever request, honoured only in IDLE
//   seed_we/seed : load the LFSR (seed must be nonzero)
//   c1, c2, c3   : reel symbols (registered)
//   busy         : spin in progress (FAST or SLOW)
//   slowing      : in the SLOW phase
//   stopped      : per-reel stop flags, bit0 = reel 1
//   done         : one-cycle pulse when all reels have stopped
module slot_reels
   import slot_pkg::*;
#(
   parameter int unsigned SYM_W      = SYM_W_DEF,
   parameter int unsigned NUM_SYMS   = NUM_SYMS_DEF,
   parameter int unsigned FAST_DIV   = 2,
   parameter int unsigned FAST_STEPS = 4,
   parameter int unsigned SLOW_DIV   = 4,
   parameter int unsigned SLOW_STEPS = 2,
   parameter int unsigned STOP_GAP   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             spin,
   input  logic             seed_we,
   input  logic [15:0]      seed,
   output logic [SYM_W-1:0] c1,
   output logic [SYM_W-1:0] c2,
   output logic [SYM_W-1:0] c3,
   output logic             busy,
   output logic             slowing,
   output logic [2:0]       stopped,
   output logic             done
);

   localparam int unsigned NUM_REELS = 3;
   localparam int unsigned MAX_DIV   = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
   localparam int unsigned DIV_W     = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
   localparam int unsigned LAST_STOP = SLOW_STEPS + 2 * STOP_GAP;
   localparam int unsigned MAX_CNT   = (FAST_STEPS > LAST_STOP) ? FAST_STEPS : LAST_STOP;
   localparam int unsigned CNT_W     = $clog2(MAX_CNT + 1);
   localparam int unsigned SNAP_W    = NUM_REELS * SYM_W;

   reel_state_e state_q, state_d;

   logic [DIV_W-1:0]                    div_q, div_d;
   logic [CNT_W-1:0]                    cnt_q, cnt_d;
   logic [NUM_REELS-1:0][SYM_W-1:0]     pos_q, pos_d;
   logic [NUM_REELS-1:0]                stopped_q, stopped_d;
   logic                                busy_q, busy_d;
   logic                                slowing_q, slowing_d;
   logic                                done_q, done_d;
   logic [SNAP_W-1:0]                   snap_c;
   logic                                tick_c;

   // Raw LFSR field to a legal position: fields past the last symbol fold down once.
   function automatic logic [SYM_W-1:0] fold_sym(input logic [SYM_W-1:0] f);
      return (32'(f) >= NUM_SYMS) ? SYM_W'(32'(f) - NUM_SYMS) : f;
   endfunction

   // One reel step with wrap from the last symbol back to 0.
   function automatic logic [SYM_W-1:0] step_sym(input logic [SYM_W-1:0] p);
      return (32'(p) == NUM_SYMS - 1) ? '0 : p + SYM_W'(1);
   endfunction

   slot_lfsr #(
      .OUT_W (SNAP_W)
   ) u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .load_i (seed_w_e_c()),
      .seed_i (seed),
      .snap_o (snap_c)
   );

   function automatic logic seed_w_e_c();
      return seed_we;
   endfunction

   // Step tick: divider has reached the phase's last count.
   always_comb begin
      tick_c = 1'b0;
      if (state_q == FAST) begin
         tick_c = (div_q == DIV_W'(FAST_DIV - 1));
      end else if (state_q == SLOW) begin
         tick_c = (div_q == DIV_W'(SLOW_DIV - 1));
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (spin) state_d = FAST;
         FAST: if (tick_c && (cnt_q == CNT_W'(FAST_STEPS - 1))) state_d = SLOW;
         SLOW: if (&stopped_d) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status outputs follow the state being entered so they line up with it.
   always_comb begin
      busy_d    = (state_d == FAST) || (state_d == SLOW);
      slowing_d = (state_d == SLOW);
      done_d    = (state_d == DONE);
   end

   // Reel datapath: snapshot, dividers, tick counting, stepping and stopping.
   always_comb begin
      div_d     = '0;
      cnt_d     = cnt_q;
      pos_d     = pos_q;
      stopped_d = stopped_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (spin) begin
               for (int k = 0; k < NUM_REELS; k++) begin
                  pos_d[k] = fold_sym(snap_c[k*SYM_W +: SYM_W]);
               end
               stopped_d = '0;
            end
         end
         FAST: begin
            div_d = tick_c ? '0 : div_q + DIV_W'(1);
            if (tick_c) begin
               for (int k = 0; k < NUM_REELS; k++) begin
                  if (!stopped_q[k]) pos_d[k] = step_sym(pos_q[k]);
               end
               // Last fast tick hands over to SLOW with the counter cleared.
               cnt_d = (cnt_q == CNT_W'(FAST_STEPS - 1)) ? '0 : cnt_q + CNT_W'(1);
            end
         end
         SLOW: begin
            div_d = tick_c ? '0 : div_q + DIV_W'(1);
            if (tick_c) begin
               cnt_d = cnt_q + CNT_W'(1);
               // Slow ticks are numbered from 1; reel k stops on its own tick
               // after taking that tick's step.
               for (int k = 0; k < NUM_REELS; k++) begin
                  if (!stopped_q[k]) begin
                     pos_d[k] = step_sym(pos_q[k]);
                     if ((32'(cnt_q) + 32'd1) == (SLOW_STEPS + 32'(k) * STOP_GAP)) begin
                        stopped_d[k] = 1'b1;
                     end
                  end
               end
            end
         end
         DONE: cnt_d = '0;
         default: cnt_d = '0;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q     <= '0;
         cnt_q     <= '0;
         pos_q     <= '0;
         stopped_q <= '0;
         busy_q    <= 1'b0;
         slowing_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         pos_q     <= pos_d;
         stopped_q <= stopped_d;
         busy_q    <= busy_d;
         slowing_q <= slowing_d;
         done_q    <= done_d;
      end
   end

   assign c1      = pos_q[0];
   assign c2      = pos_q[1];
   assign c3      = pos_q[2];
   assign stopped = stopped_q;
   assign busy    = busy_q;
   assign slowing = slowing_q;
   assign done    = done_q;

endmodule

// File: tb/tb_slot_reels.sv
// Directed bench for slot_reels with default parameters: per-cycle timeline
// checks for table-driven seeded spins plus hand-written corner sequences.
module tb_slot_reels;

   logic        clk = 1'b0;
   logic        reset;
   logic        spin;
   logic        seed_we;
   logic [15:0] seed;
   logic [2:0]  c1, c2, c3;
   logic        busy, slowing, done;
   logic [2:0]  stopped;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] m_lfsr;

   typedef struct {
      logic [15:0] seed;
      int          s1, s2, s3;
      int          f1, f2, f3;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   slot_reels dut (
      .clk     (clk),
      .reset   (reset),
      .spin    (spin),
      .seed_we (seed_we),
      .seed    (seed),
      .c1      (c1),
      .c2      (c2),
      .c3      (c3),
      .busy    (busy),
      .slowing (slowing),
      .stopped (stopped),
      .done    (done)
   );

   // Reference LFSR: x^16+x^14+x^13+x^11, right-shifting, 0xACE1 at reset.
   always @(posedge clk) begin
      if (reset)        m_lfsr <= 16'hACE1;
      else if (seed_we) m_lfsr <= seed;
      else              m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int fold3(input logic [2:0] f);
      return (f >= 3'd6) ? int'(f) - 6 : int'(f);
   endfunction

   // Steps visible in cycle n for reel k (0-based). Tick cycles with
   // defaults: fast 2,4,6,8; slow 12,16,20,24; reel k takes the first 6+k.
   function automatic int adv(input int n, input int k);
      int ticks[8] = '{2, 4, 6, 8, 12, 16, 20, 24};
      int a = 0;
      for (int i = 0; i < 6 + k; i++) if (ticks[i] < n) a++;
      return a;
   endfunction

   function automatic logic [31:0] outs();
      return 32'({c1, c2, c3, busy, slowing, stopped, done});
   endfunction

   // Expected outputs in cycle n after a spin accepted in cycle 0.
   task automatic check_cycle(input int n, input int s1, input int s2, input int s3);
      logic [2:0] e1, e2, e3, est;
      logic       eb, es, ed;
      e1  = 3'((s1 + adv(n, 0)) % 6);
      e2  = 3'((s2 + adv(n, 1)) % 6);
      e3  = 3'((s3 + adv(n, 2)) % 6);
      eb  = (n >= 1) && (n <= 24);
      es  = (n >= 9) && (n <= 24);
      ed  = (n == 25);
      est = {n >= 25, n >= 21, n >= 17};
      check($sformatf("cyc%0d {c1,c2,c3,busy,slowing,stopped,done}", n),
            outs(), 32'({e1, e2, e3, eb, es, est, ed}));
   endtask

   // Spin in the current (IDLE) cycle and check every cycle through 26.
   task automatic run_spin(input logic use_seed, input logic [15:0] sd,
                           input int s1, input int s2, input int s3, input logic pulse);
      int done_cnt = 0;
      spin = 1'b1; seed_we = use_seed; seed = sd;
      tick();
      spin = 1'b0; seed_we = 1'b0;
      for (int n = 1; n <= 26; n++) begin
         check_cycle(n, s1, s2, s3);
         if (done === 1'b1) done_cnt++;
         spin = pulse && ((n == 5) || (n == 15));
         if (n < 26) tick();
      end
      spin = 1'b0;
      check("done_once", 32'(done_cnt), 32'd1);
   endtask

   initial begin
      logic [15:0] snap;
      int          seen;

      vecs[0] = '{seed: 16'h0111, s1: 1, s2: 2, s3: 4, f1: 1, f2: 3, f3: 0};
      vecs[1] = '{seed: 16'h01FF, s1: 1, s2: 1, s3: 1, f1: 1, f2: 2, f3: 3};
      vecs[2] = '{seed: 16'h00B6, s1: 0, s2: 0, s3: 2, f1: 0, f2: 1, f3: 4};
      vecs[3] = '{seed: 16'h0088, s1: 0, s2: 1, s3: 2, f1: 0, f2: 2, f3: 4};
      vecs[4] = '{seed: 16'h016D, s1: 5, s2: 5, s3: 5, f1: 5, f2: 0, f3: 1};

      reset = 1'b1; spin = 1'b0; seed_we = 1'b0; seed = 16'h0;
      repeat (3) tick();
      check("reset_outputs", outs(), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check($sformatf("idle%0d", i), outs(), 32'd0);
      end

      // Seeded spins from the vector table.
      for (int i = 0; i < 5; i++) begin
         run_spin(1'b1, vecs[i].seed, vecs[i].s1, vecs[i].s2, vecs[i].s3, 1'b0);
         check($sformatf("final_v%0d", i), 32'({c1, c2, c3}),
               32'({3'(vecs[i].f1), 3'(vecs[i].f2), 3'(vecs[i].f3)}));
      end

      // Spin pulses mid-run are ignored.
      run_spin(1'b1, 16'h0111, 1, 2, 4, 1'b1);
      check("ignored_final", 32'({c1, c2, c3}), 32'({3'd1, 3'd3, 3'd0}));

      // Reset in cycle 12 aborts the run without a done pulse.
      seen = 0;
      spin = 1'b1; seed_we = 1'b1; seed = 16'h0111;
      tick();
      spin = 1'b0; seed_we = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         check_cycle(n, 1, 2, 4);
         if (done === 1'b1) seen++;
         if (n < 12) tick();
      end
      reset = 1'b1;
      tick();
      check("abort_outputs", outs(), 32'd0);
      if (done === 1'b1) seen++;
      check("abort_no_done", 32'(seen), 32'd0);
      reset = 1'b0;
      tick();
      run_spin(1'b1, 16'h01FF, 1, 1, 1, 1'b0);
      check("after_abort_final", 32'({c1, c2, c3}), 32'({3'd1, 3'd2, 3'd3}));

      // Reset beats a simultaneous seed load: next spin starts from 0xACE1.
      reset = 1'b1; seed_we = 1'b1; seed = 16'h0111;
      tick();
      reset = 1'b0; seed_we = 1'b0;
      run_spin(1'b0, 16'h0, 1, 4, 3, 1'b0);
      check("reset_seed_final", 32'({c1, c2, c3}), 32'({3'd1, 3'd5, 3'd5}));

      // Free-running LFSR snapshots after two different idle gaps.
      repeat (7) tick();
      snap = m_lfsr;
      check("lfsr_nonzero_a", 32'(snap != 16'h0), 32'd1);
      run_spin(1'b0, 16'h0, fold3(snap[2:0]), fold3(snap[5:3]), fold3(snap[8:6]), 1'b0);
      repeat (13) tick();
      snap = m_lfsr;
      check("lfsr_nonzero_b", 32'(snap != 16'h0), 32'd1);
      run_spin(1'b0, 16'h0, fold3(snap[2:0]), fold3(snap[5:3]), fold3(snap[8:6]), 1'b0);

      // Spin held through SLOW and DONE is taken on the first IDLE cycle.
      spin = 1'b1; seed_we = 1'b1; seed = 16'h0088;
      tick();
      spin = 1'b0; seed_we = 1'b0;
      for (int n = 1; n <= 26; n++) begin
         check_cycle(n, 0, 1, 2);
         if (n == 26) snap = m_lfsr;
         spin = (n >= 24);
         tick();
      end
      spin = 1'b0;
      check("held_spin_busy", 32'(busy), 32'd1);
      check("held_spin_start", 32'({c1, c2, c3}),
            32'({3'(fold3(snap[2:0])), 3'(fold3(snap[5:3])), 3'(fold3(snap[8:6]))}));
      seen = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
         tick();
         if (done === 1'b1) seen = 1;
      end
      check("held_spin_done", 32'(seen), 32'd1);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/slot_reels.md
Name: slot_reels

Overview:
- Reel generator directly upstream of the slot-machine game FSM.
- Spins three reel columns, runs a fast phase then a slow phase, and stops the reels one at a time.
- Drives the c1/c2/c3 symbol buses that the game FSM compares for a win, plus busy/done status.
- Start positions come from a free-running LFSR, so the result depends on when the lever is pulled.

Parameters:
- SYM_W, 3, symbol width in bits; NUM_SYMS must satisfy 2**(SYM_W-1) < NUM_SYMS <= 2**SYM_W.
- NUM_SYMS, 6, number of symbols per reel; positions are 0..NUM_SYMS-1 and wrap.
- FAST_DIV, 2, clock cycles per reel step in the fast phase (>=1).
- FAST_STEPS, 4, number of step ticks in the fast phase (>=1).
- SLOW_DIV, 4, clock cycles per reel step in the slow phase (>=1).
- SLOW_STEPS, 2, slow-phase tick on which reel 1 stops (>=1).
- STOP_GAP, 1, extra slow ticks between successive reel stops (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- spin  input  1  lever request; sampled only in IDLE.
- seed_we  input  1  test/load strobe: writes the LFSR.
- seed  input  16  LFSR load value; must be nonzero.
- c1  output  SYM_W  reel 1 symbol.
- c2  output  SYM_W  reel 2 symbol.
- c3  output  SYM_W  reel 3 symbol.
- busy  output  1  high from the cycle after spin is accepted until done.
- slowing  output  1  high while in the SLOW state.
- stopped  output  3  per-reel stop flags; bit0 is reel 1.
- done  output  1  one-cycle pulse: all reels stopped and c1..c3 final.

Behaviour:
- Reset: state=IDLE, c1=c2=c3=0, busy=slowing=done=0, stopped=3'b000, lfsr=16'hACE1, dividers and tick counters cleared.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11. Shifts every cycle in every state. seed_we loads seed instead of shifting (seed_we has priority over shifting).
- States: IDLE -> FAST -> SLOW -> DONE -> IDLE.
- IDLE, spin=1: snapshot start positions.
  - Snapshot source is seed if seed_we is high that cycle, else the current lfsr.
  - c1=snap[2:0], c2=snap[5:3], c3=snap[8:6].
  - Any field >= NUM_SYMS has NUM_SYMS subtracted (default: 6->0, 7->1).
  - stopped is cleared and next state is FAST.
- Tick generation: the divider counts 0..DIV-1 and ticks when it equals DIV-1. It clears on entry to FAST and on entry to SLOW.
- On each tick, every reel with stopped[k]=0 advances: pos = (pos==NUM_SYMS-1) ? 0 : pos+1.
- FAST: after the FAST_STEPS-th tick (that tick still advances), go to SLOW.
- SLOW: slowing=1. Slow ticks are counted from 1.
  - On tick SLOW_STEPS + k*STOP_GAP, reel k+1 advances and then sets stopped[k].
  - A stopped reel holds its symbol.
  - When stopped becomes 3'b111, go to DONE.
- DONE: lasts one cycle with done=1 and busy=0, then IDLE.
- c1..c3 hold their final values in IDLE until the next accepted spin.
- Latency with defaults: spin accepted in cycle 0, FAST in cycles 1-8, SLOW in cycles 9-24, done=1 in cycle 25.
- Advances per reel: FAST_STEPS + SLOW_STEPS + k*STOP_GAP, i.e. 6/7/8 with defaults.
- spin outside IDLE is ignored (no queueing). spin held high through DONE is accepted on the first IDLE cycle.
- reset mid-spin aborts on the next edge to reset values; done is not pulsed.
- reset with seed_we in the same cycle: reset wins.

Decomposition:
- Package slot_pkg holds:
  - the reel state enum (IDLE, FAST, SLOW, DONE);
  - SYM_W and NUM_SYMS defaults;
  - LFSR_RESET=16'hACE1 and the tap mask;
  - the symbol typedef, shared with the game FSM for c1..c3.
- One sub-module, slot_lfsr: 16-bit LFSR with load. The reel stepping and FSM stay in slot_reels.

Test Plan:
- Reset check: hold reset for 3 cycles -> c1=c2=c3=0, busy=0, stopped=000, done=0. Idle for 20 cycles -> no output change.
- Seeded spin: seed_we=1, seed=16'h0111, and spin=1 in the same cycle -> starts 1/2/4.
  - stopped[0] rises at cycle 17, stopped[1] at cycle 21, stopped[2] at cycle 25 (the done cycle).
  - done pulses at cycle 25; final c1=1, c2=3, c3=0.
- Field wrap: seed=16'h01FF (fields 7/7/7) with spin -> starts 1/1/1 -> final c1=1, c2=2, c3=3.
  - The bench checks that pos 5 -> 0 wraps on every step.
- Ignored spin: pulse spin at cycles 5 and 15 during a run -> the timeline is unchanged and done pulses exactly once.
- Reset mid-spin: assert reset at cycle 12 -> next cycle all outputs are at reset values, there is no done pulse, and a fresh spin works normally.
- Free-running LFSR: two spins with no seed and different idle gaps -> the lfsr value never equals 0 and the start snapshot matches a bench LFSR model.
